// File: rtl/decode_queue_if.sv
// rtl/decode_queue_if.sv - Fetch-side and issue-side handshake bundle for decode_queue; DECODE_ILLEGAL_TRAP_EN adds out_illegal
interface decode_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        in_pred_taken;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_op_type;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic        out_pred_taken;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, in_pred_taken, out_ready,
        input  in_ready, out_valid, out_op_type, out_rd, out_rs1, out_rs2,
               out_imm, out_pc, out_pred_taken, out_illegal
    );
    modport slave (
        input  in_valid, in_inst, in_pc, in_pred_taken, out_ready,
        output in_ready, out_valid, out_op_type, out_rd, out_rs1, out_rs2,
               out_imm, out_pc, out_pred_taken, out_illegal
    );
`else
    modport master (
        output in_valid, in_inst, in_pc, in_pred_taken, out_ready,
        input  in_ready, out_valid, out_op_type, out_rd, out_rs1, out_rs2,
               out_imm, out_pc, out_pred_taken
    );
    modport slave (
        input  in_valid, in_inst, in_pc, in_pred_taken, out_ready,
        output in_ready, out_valid, out_op_type, out_rd, out_rs1, out_rs2,
               out_imm, out_pc, out_pred_taken
    );
`endif
endinterface

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - Buffered RV32I decoder: FIFO of fetched instructions feeding a registered decoded output slot
// DECODE_ILLEGAL_TRAP_EN: deliver OP_NULL entries with out_illegal instead of dropping them at pop
module decode_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            flush_in,
    decode_queue_if.slave   io,
    output logic [ADDR_W:0] count_out
);
    localparam logic [5:0] OP_NULL = 6'd0,  OP_LUI  = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL  = 6'd3,
                           OP_JALR = 6'd4,  OP_BEQ  = 6'd5,  OP_BNE   = 6'd6,  OP_BLT  = 6'd7,
                           OP_BGE  = 6'd8,  OP_BLTU = 6'd9,  OP_BGEU  = 6'd10, OP_LB   = 6'd11,
                           OP_LH   = 6'd12, OP_LW   = 6'd13, OP_LBU   = 6'd14, OP_LHU  = 6'd15,
                           OP_SB   = 6'd16, OP_SH   = 6'd17, OP_SW    = 6'd18, OP_ADDI = 6'd19,
                           OP_SLTI = 6'd20, OP_SLTIU = 6'd21, OP_XORI = 6'd22, OP_ORI  = 6'd23,
                           OP_ANDI = 6'd24, OP_SLLI = 6'd25, OP_SRLI  = 6'd26, OP_SRAI = 6'd27,
                           OP_ADD  = 6'd28, OP_SUB  = 6'd29, OP_SLL   = 6'd30, OP_SLT  = 6'd31,
                           OP_SLTU = 6'd32, OP_XOR  = 6'd33, OP_SRL   = 6'd34, OP_SRA  = 6'd35,
                           OP_OR   = 6'd36, OP_AND  = 6'd37;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [64:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [5:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [31:0]       imm_q, imm_d, pc_q, pc_d;
    logic              pred_q, pred_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic              ill_q, ill_d;
`endif

    logic [64:0] head;
    logic [31:0] inst;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [5:0]  dec_op;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic [31:0] dec_imm;
    logic        push, pop, xfer, load;

    assign head = mem_q[rd_ptr_q];
    assign inst = head[31:0];

    always_comb begin
        opcode  = inst[6:0];
        f3      = inst[14:12];
        f7      = inst[31:25];
        imm_i   = {{20{inst[31]}}, inst[31:20]};
        imm_s   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        imm_b   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_u   = {inst[31:12], 12'b0};
        imm_j   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        dec_op  = OP_NULL;
        dec_rd  = inst[11:7];
        dec_rs1 = inst[19:15];
        dec_rs2 = inst[24:20];
        dec_imm = '0;
        case (opcode)
            7'b0110111: begin dec_op = OP_LUI;   dec_rs1 = '0; dec_rs2 = '0; dec_imm = imm_u; end
            7'b0010111: begin dec_op = OP_AUIPC; dec_rs1 = '0; dec_rs2 = '0; dec_imm = imm_u; end
            7'b1101111: begin dec_op = OP_JAL;   dec_rs1 = '0; dec_rs2 = '0; dec_imm = imm_j; end
            7'b1100111: begin
                dec_rs2 = '0;
                dec_imm = imm_i;
                if (f3 == 3'd0) dec_op = OP_JALR;
            end
            7'b1100011: begin
                dec_rd  = '0;
                dec_imm = imm_b;
                case (f3)
                    3'd0: dec_op = OP_BEQ;
                    3'd1: dec_op = OP_BNE;
                    3'd4: dec_op = OP_BLT;
                    3'd5: dec_op = OP_BGE;
                    3'd6: dec_op = OP_BLTU;
                    3'd7: dec_op = OP_BGEU;
                    default: ;
                endcase
            end
            7'b0000011: begin
                dec_rs2 = '0;
                dec_imm = imm_i;
                case (f3)
                    3'd0: dec_op = OP_LB;
                    3'd1: dec_op = OP_LH;
                    3'd2: dec_op = OP_LW;
                    3'd4: dec_op = OP_LBU;
                    3'd5: dec_op = OP_LHU;
                    default: ;
                endcase
            end
            7'b0100011: begin
                dec_rd  = '0;
                dec_imm = imm_s;
                case (f3)
                    3'd0: dec_op = OP_SB;
                    3'd1: dec_op = OP_SH;
                    3'd2: dec_op = OP_SW;
                    default: ;
                endcase
            end
            7'b0010011: begin
                dec_rs2 = '0;
                dec_imm = imm_i;
                case (f3)
                    3'd0: dec_op = OP_ADDI;
                    3'd2: dec_op = OP_SLTI;
                    3'd3: dec_op = OP_SLTIU;
                    3'd4: dec_op = OP_XORI;
                    3'd6: dec_op = OP_ORI;
                    3'd7: dec_op = OP_ANDI;
                    3'd1: if (f7 == 7'h00) dec_op = OP_SLLI;
                    3'd5: begin
                        if (f7 == 7'h00)      dec_op = OP_SRLI;
                        else if (f7 == 7'h20) dec_op = OP_SRAI;
                    end
                    default: ;
                endcase
            end
            7'b0110011: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: dec_op = OP_ADD;
                        3'd1: dec_op = OP_SLL;
                        3'd2: dec_op = OP_SLT;
                        3'd3: dec_op = OP_SLTU;
                        3'd4: dec_op = OP_XOR;
                        3'd5: dec_op = OP_SRL;
                        3'd6: dec_op = OP_OR;
                        default: dec_op = OP_AND;
                    endcase
                end else if (f7 == 7'h20) begin
                    if (f3 == 3'd0)      dec_op = OP_SUB;
                    else if (f3 == 3'd5) dec_op = OP_SRA;
                end
            end
            default: ;
        endcase
        // Illegal encodings carry no operand information downstream.
        if (dec_op == OP_NULL) begin
            dec_rd  = '0;
            dec_rs1 = '0;
            dec_rs2 = '0;
            dec_imm = '0;
        end
    end

    always_comb begin
        push = rdy_in && !flush_in && io.in_valid && (count_q != DEPTH_C);
        pop  = rdy_in && !flush_in && (count_q != '0) && (!out_valid_q || io.out_ready);
        xfer = rdy_in && !flush_in && out_valid_q && io.out_ready;
`ifdef DECODE_ILLEGAL_TRAP_EN
        load = pop;
`else
        load = pop && (dec_op != OP_NULL);
`endif
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        op_d        = op_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        pred_d      = pred_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
        ill_d       = ill_q;
`endif
        if (flush_in) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: ;
            endcase
            if (load) begin
                out_valid_d = 1'b1;
                op_d        = dec_op;
                rd_d        = dec_rd;
                rs1_d       = dec_rs1;
                rs2_d       = dec_rs2;
                imm_d       = dec_imm;
                pc_d        = head[63:32];
                pred_d      = head[64];
`ifdef DECODE_ILLEGAL_TRAP_EN
                ill_d       = (dec_op == OP_NULL);
`endif
            end else if (xfer) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q] <= {io.in_pred_taken, io.in_pc, io.in_inst};
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            op_q        <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            pred_q      <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            ill_q       <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            pred_q      <= pred_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
            ill_q       <= ill_d;
`endif
        end
    end

    assign io.in_ready       = rdy_in && (count_q != DEPTH_C);
    assign io.out_valid      = out_valid_q;
    assign io.out_op_type    = op_q;
    assign io.out_rd         = rd_q;
    assign io.out_rs1        = rs1_q;
    assign io.out_rs2        = rs2_q;
    assign io.out_imm        = imm_q;
    assign io.out_pc         = pc_q;
    assign io.out_pred_taken = pred_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign io.out_illegal    = ill_q;
`endif
    assign count_out         = count_q;
endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - Directed and randomized self-checking bench for decode_queue against a mask/match RV32I model
`timescale 1ns/1ps
module tb_decode_queue;
    localparam int DEPTH = 8;
    typedef logic [86:0] vec_t;   // {op6, rd5, rs1_5, rs2_5, imm32, pc32, pred1, illegal1}

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       rdy_in = 1'b0;
    logic       flush_in = 1'b0;
    logic [3:0] count_out;

    decode_queue_if io ();

    decode_queue #(.DEPTH(DEPTH)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush_in (flush_in),
        .io       (io),
        .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    logic [64:0] mdl_fifo [$];
    logic        mdl_v = 1'b0;
    vec_t        mdl_slot = '0;

    // Match values in OP_* order; index i is op code i+1.
    localparam logic [31:0] MATCH_T [37] = '{
        32'h37, 32'h17, 32'h6f, 32'h67,
        32'h63, 32'h1063, 32'h4063, 32'h5063, 32'h6063, 32'h7063,
        32'h3, 32'h1003, 32'h2003, 32'h4003, 32'h5003,
        32'h23, 32'h1023, 32'h2023,
        32'h13, 32'h2013, 32'h3013, 32'h4013, 32'h6013, 32'h7013,
        32'h1013, 32'h5013, 32'h40005013,
        32'h33, 32'h40000033, 32'h1033, 32'h2033, 32'h3033, 32'h4033,
        32'h5033, 32'h40005033, 32'h6033, 32'h7033};

    function automatic vec_t model_exp(logic [64:0] e);
        logic [31:0] w = e[31:0];
        logic [31:0] sgn = w[31] ? 32'hfffff000 : 32'h0;
        logic [31:0] mask;
        logic [31:0] imm;
        logic [4:0]  rd, rs1, rs2;
        int op = 0;
        for (int i = 0; i < 37; i++) begin
            mask = (i < 3) ? 32'h7f : (i < 24) ? 32'h707f : 32'hfe00707f;
            if (op == 0 && (w & mask) == MATCH_T[i]) op = i + 1;
        end
        rd  = w[11:7];
        rs1 = w[19:15];
        rs2 = w[24:20];
        imm = sgn | (w >> 20);
        if (op == 0) begin
            rd = 0; rs1 = 0; rs2 = 0; imm = 0;
        end else if (op <= 2) begin
            rs1 = 0; rs2 = 0; imm = w & 32'hfffff000;
        end else if (op == 3) begin
            rs1 = 0; rs2 = 0;
            imm = (w[31] ? 32'hfff00000 : 32'h0) | (w & 32'h000ff000) | ((w >> 9) & 32'h800) | ((w >> 20) & 32'h7fe);
        end else if (op >= 5 && op <= 10) begin
            rd = 0;
            imm = sgn | ((w << 4) & 32'h800) | ((w >> 20) & 32'h7e0) | ((w >> 7) & 32'h1e);
        end else if (op >= 16 && op <= 18) begin
            rd = 0;
            imm = sgn | ((w >> 20) & 32'hfe0) | ((w >> 7) & 32'h1f);
        end else if (op >= 28) begin
            imm = 0;
        end else begin
            rs2 = 0;
        end
        return {6'(op), rd, rs1, rs2, imm, e[63:32], e[64], (op == 0)};
    endfunction

    function automatic vec_t dut_vec();
        logic ill = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        ill = io.out_illegal;
`endif
        return {io.out_op_type, io.out_rd, io.out_rs1, io.out_rs2, io.out_imm, io.out_pc, io.out_pred_taken, ill};
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: FIFO occupancy plus one output slot, advanced once per edge.
    always @(posedge clk_in) begin
        logic can_push;
        vec_t e;
        if (rst_in) begin
            if (flush_in) begin
                mdl_fifo.delete();
                mdl_v = 1'b0;
            end else if (rdy_in) begin
                can_push = io.in_valid && (mdl_fifo.size() < DEPTH);
                if (mdl_fifo.size() > 0 && (!mdl_v || io.out_ready)) begin
                    e = model_exp(mdl_fifo.pop_front());
`ifdef DECODE_ILLEGAL_TRAP_EN
                    mdl_slot = e; mdl_v = 1'b1;
`else
                    if (e[0]) mdl_v = 1'b0;
                    else begin mdl_slot = e; mdl_v = 1'b1; end
`endif
                end else if (mdl_v && io.out_ready) begin
                    mdl_v = 1'b0;
                end
                if (can_push) mdl_fifo.push_back({io.in_pred_taken, io.in_pc, io.in_inst});
            end
        end
    end

    always @(negedge clk_in) begin
        if (rst_in) begin
            chk("count_out", count_out, mdl_fifo.size());
            chk("in_ready", io.in_ready, rdy_in && (mdl_fifo.size() < DEPTH));
            chk("out_valid", io.out_valid, mdl_v);
            if (mdl_v && io.out_valid) chk("out_fields", dut_vec(), mdl_slot);
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_now(logic [31:0] inst, logic [31:0] pc);
        io.in_valid = 1'b1;
        io.in_inst = inst;
        io.in_pc = pc;
        io.in_pred_taken = pc[2];
    endtask

    task automatic fill4();
        for (int i = 0; i < 4; i++) begin
            push_now(32'h00100093 + (i << 20), 32'h5000 + 4 * i);
            step();
        end
        io.in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w = $urandom();
        logic [6:0] opc [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        if ($urandom_range(9) != 0) w[6:0] = opc[$urandom_range(8)];
        if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(3) != 0)
            w[31:25] = ($urandom_range(1) != 0) ? 7'h20 : 7'h00;
        return w;
    endfunction

    initial begin
        int acc;
        io.in_valid = 1'b0; io.in_inst = '0; io.in_pc = '0; io.in_pred_taken = 1'b0; io.out_ready = 1'b0;
        rdy_in = 1'b1;
        #1;
        chk("reset_count", count_out, 0);
        chk("reset_out_valid", io.out_valid, 0);
        chk("reset_in_ready", io.in_ready, 1);
        chk("reset_fields", dut_vec(), 0);
        step(); step();
        rst_in = 1'b1;
        step();

        chk("model_addi", model_exp({1'b0, 32'h1000, 32'h00500093}), {6'd19, 5'd1, 5'd0, 5'd0, 32'd5, 32'h1000, 1'b0, 1'b0});
        chk("model_beq", model_exp({1'b1, 32'h0, 32'hFE000EE3}), {6'd5, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'h0, 1'b1, 1'b0});
        chk("model_null", model_exp({1'b0, 32'h0, 32'hFFFFFFFF}), {6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0, 1'b0, 1'b1});

        push_now(32'h00500093, 32'h1000);
        step();
        io.in_valid = 1'b0;
        step();
        chk("addi_valid", io.out_valid, 1);
        chk("addi_fields", dut_vec(), {6'd19, 5'd1, 5'd0, 5'd0, 32'd5, 32'h1000, 1'b0, 1'b0});
        io.out_ready = 1'b1;
        step();

        push_now(32'h123450B7, 32'h1004);
        step();
        push_now(32'hFE000EE3, 32'h1008);
        step();
        io.in_valid = 1'b0;
        chk("lui_fields", dut_vec(), {6'd1, 5'd1, 5'd0, 5'd0, 32'h12345000, 32'h1004, 1'b1, 1'b0});
        step();
        chk("beq_valid", io.out_valid, 1);
        chk("beq_fields", dut_vec(), {6'd5, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'h1008, 1'b0, 1'b0});
        step();

        io.out_ready = 1'b0;
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        acc = 0;
        push_now(32'h00500093, 32'h3000);
        for (int i = 0; i < 12; i++) begin
            if (io.in_ready) acc++;
            step();
        end
        chk("full_accepted", acc, 9);
        chk("full_count", count_out, 8);
        chk("full_in_ready", io.in_ready, 0);
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        step();
        io.out_ready = 1'b0;
        chk("after_pop_count", count_out, 7);
        chk("after_pop_in_ready", io.in_ready, 1);

        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        fill4();
        chk("fill_count", count_out, 3);
        chk("fill_out_valid", io.out_valid, 1);
        flush_in = 1'b1;
        push_now(32'h00A00093, 32'h4000);
        step();
        flush_in = 1'b0;
        io.in_valid = 1'b0;
        chk("flush_count", count_out, 0);
        chk("flush_out_valid", io.out_valid, 0);
        io.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_no_ghost", io.out_valid, 0);
        end

        push_now(32'hFFFFFFFF, 32'h2000);
        step();
        push_now(32'h00500093, 32'h2004);
        step();
        io.in_valid = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("illegal_valid", io.out_valid, 1);
        chk("illegal_fields", dut_vec(), {6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h2000, 1'b0, 1'b1});
`else
        chk("illegal_dropped", io.out_valid, 0);
`endif
        step();
        chk("post_illegal_valid", io.out_valid, 1);
        chk("post_illegal_fields", dut_vec(), {6'd19, 5'd1, 5'd0, 5'd0, 32'd5, 32'h2004, 1'b1, 1'b0});
        step();

        io.out_ready = 1'b0;
        fill4();
        chk("pre_reset_count", count_out, 3);
        rst_in = 1'b0;
        mdl_fifo.delete();
        mdl_v = 1'b0;
        #1;
        chk("midreset_count", count_out, 0);
        chk("midreset_out_valid", io.out_valid, 0);
        chk("midreset_in_ready", io.in_ready, 1);
        step();
        rst_in = 1'b1;
        step();

        for (int i = 0; i < 3000; i++) begin
            rdy_in = ($urandom_range(9) != 0);
            flush_in = ($urandom_range(49) == 0);
            io.out_ready = ($urandom_range(2) != 0);
            io.in_valid = ($urandom_range(9) < 7);
            io.in_inst = rand_inst();
            io.in_pc = $urandom() & 32'hfffffffc;
            io.in_pred_taken = $urandom_range(1) != 0;
            step();
        end
        rdy_in = 1'b1;
        flush_in = 1'b0;
        io.in_valid = 1'b0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
# decode_queue

Buffered, handshaked RV32I instruction decoder sitting between instruction fetch and issue/dispatch. Fetched instructions (with PC and predictor bit) are written into a DEPTH-entry FIFO. The head entry is decoded and moved into a registered output slot that the issue stage consumes through a valid/ready handshake. The block supports pipeline flush on mispredict and a global `rdy_in` stall.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; power of two, minimum 2.
- `ADDR_W`, default `$clog2(DEPTH)`: pointer width.

Ports:
- `clk_in`  in  1  clock.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `rdy_in`  in  1  global enable; low = freeze all state.
- `flush_in`  in  1  discard all buffered and output entries.
- `in_valid`  in  1  fetch offers an instruction.
- `in_ready`  out  1  `rdy_in && count < DEPTH`.
- `in_inst`  in  32  raw instruction.
- `in_pc`  in  32  instruction PC.
- `in_pred_taken`  in  1  predictor decision.
- `out_valid`  out  1  output slot holds a decoded instruction.
- `out_ready`  in  1  issue stage accepts.
- `out_op_type`  out  6  `OP_*` code from utils.v.
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  register indices.
- `out_imm`  out  32  sign-extended/shifted immediate.
- `out_pc`  out  32  copied from `in_pc`.
- `out_pred_taken`  out  1  copied from `in_pred_taken`.
- `count_out`  out  ADDR_W+1  FIFO occupancy, excluding the output slot.
- `out_illegal`  out  1  present only with the macro below.

## Operation
- Push: `in_valid && in_ready` at a clock edge writes the entry at `wr_ptr`, then `wr_ptr++` (mod DEPTH).
- Pop: allowed when `count > 0` and the output slot is free. The slot is free when `!out_valid`, or when `out_valid && out_ready` (same-cycle refill).
- On pop, the head is decoded combinationally, all out_* fields are registered, and `rd_ptr++` (mod DEPTH).
- Push and pop in the same edge leave `count` unchanged.
- Output transfer: occurs when `out_valid && out_ready && rdy_in`. `out_valid` then clears unless refilled in the same edge.
- Decode coverage is RV32I LUI, AUIPC, JAL, JALR, OP, OP-IMM, LOAD, STORE and BRANCH, with funct3/funct7 disambiguation.
- Immediate formats:
  - U: `inst[31:12]<<12`.
  - J: sign-extend `{31,19:12,20,30:21,0}`.
  - I: sign-extend `inst[31:20]`.
  - S: sign-extend `{31:25,11:7}`.
  - B: sign-extend `{31,7,30:25,11:8,0}`.
- Register fields not used by the format are forced to 0: rd=0 for S/B, rs2=0 for I/U/J, rs1=0 for U/J.
- Unknown opcode, or a reserved funct3/funct7 combination: op_type=`OP_NULL` and rd/rs1/rs2/imm all 0.
- Flush has the highest priority. At the next edge, pointers and count go to 0 and `out_valid` goes to 0. Any push or pop in that cycle is discarded.
- `rdy_in=0`: no pointer, count or output change. Out handshakes that cycle do not count as transfers.
- Total capacity is DEPTH+1 instructions: DEPTH in the FIFO plus one in the output slot.

## Timing
- Reset, asserted asynchronously: pointers=0, count_out=0, out_valid=0, all out_* fields=0, out_illegal=0. Consequently in_ready=1 whenever rdy_in=1.
- Latency: push at edge E0 → pop at E1 → `out_valid=1` after E1. The minimum is 2 edges from acceptance to presentation.
- Throughput: 1 instruction/cycle sustained when `out_ready=1`.
- in_ready depends only on registered count and rdy_in. Pushing while full is impossible even if a pop happens the same edge.
- Reset asserted mid-transfer aborts it; no partial entry survives.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined:
  - The `out_illegal` port exists.
  - `OP_NULL` entries are delivered like any other entry, with `out_illegal=1` and `out_pc` valid so the issue stage can raise a trap.
- Undefined:
  - There is no `out_illegal` port.
  - `OP_NULL` entries are dropped at pop: the FIFO advances and the output slot is not loaded. The next legal instruction may pop on the following edge.

## Test plan
- Reset mid-traffic: 3 entries queued with out_valid=1, drive `rst_in=0` → immediately count_out=0, out_valid=0, in_ready=1 (with rdy_in=1).
- Push 0x00500093 at pc 0x1000 → 2 edges later: OP_ADDI, rd=1, rs1=0, rs2=0, imm=5, out_pc=0x1000.
- Push 0x123450B7 then 0xFE000EE3 with out_ready=1 → OP_LUI rd=1 imm=0x12345000, then OP_BEQ rd=0 rs1=0 rs2=0 imm=0xFFFFFFFC on consecutive cycles.
- DEPTH=8, out_ready=0, in_valid held → exactly 9 accepted, count_out=8, in_ready=0. Raise out_ready for 1 cycle → one pop, in_ready=1 the next cycle.
- 3 entries queued plus a valid output; assert flush_in with in_valid=1 → next cycle count_out=0, out_valid=0, and the pushed instruction never appears.
- Push 0xFFFFFFFF then 0x00500093:
  - With the macro: out_illegal=1 with OP_NULL first, then OP_ADDI.
  - Without the macro: only OP_ADDI is presented.
